aes128_sbox_engine: RTL

//  Multi-cycle SubBytes/InvSubBytes engine for the AES-128 datapath.

---
 rtl/aes128_sbox_engine.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/aes128_sbox_engine.sv
// aes128_sbox_engine: multi-cycle SubBytes/InvSubBytes engine, LANES bytes per beat.
// S-boxes are computed as GF(2^8) inverse plus affine map rather than stored tables.
package aes128_gf_pkg;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

endpackage

module aes128_rijndael_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    import aes128_gf_pkg::*;

    logic [7:0] x;

    assign x = ginv(a);
    assign s = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;

endmodule

module aes128_rijndael_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    import aes128_gf_pkg::*;

    logic [7:0] x;

    assign x = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign s = ginv(x);

endmodule

module aes128_sbox_engine #(
    parameter int WORD_BYTES = 16,
    parameter int LANES      = 4,
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    mode_i,
    input  logic [8*WORD_BYTES-1:0] data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [8*WORD_BYTES-1:0] data_o,
    output logic                    busy_o
);

    localparam int NUM_BEATS = WORD_BYTES / LANES;
    localparam int CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);

    if ((WORD_BYTES % LANES) != 0) begin : g_chk
        $error("aes128_sbox_engine: WORD_BYTES must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q;
    logic [CW-1:0]           beat_q;
    logic [8*WORD_BYTES-1:0] word_q;
    logic [8*WORD_BYTES-1:0] word_nxt;
    logic                    mode_q;
    logic                    valid_q;
    logic                    busy_q;
    logic [7:0]              lane_out [LANES];
    logic                    accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] lin;
        logic [7:0] fwd;
        logic [7:0] inv;
        assign lin = word_q[(int'(beat_q) * LANES + i) * 8 +: 8];
        aes128_rijndael_sbox u_fwd (.a(lin), .s(fwd));
        if (INVERSE_EN) begin : g_inv
            aes128_rijndael_inv_sbox u_inv (.a(lin), .s(inv));
        end else begin : g_fwd_only
            assign inv = fwd;
        end
        assign lane_out[i] = mode_q ? inv : fwd;
    end

    always_comb begin
        word_nxt = word_q;
        for (int i = 0; i < LANES; i++)
            word_nxt[(int'(beat_q) * LANES + i) * 8 +: 8] = lane_out[i];
    end

    assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = valid_q;
    assign busy_o      = busy_q;
    // only a finished word is ever visible on the output
    assign data_o      = valid_q ? word_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (state_q == BUSY) begin
            word_q <= word_nxt;
            if (beat_q == LAST) begin
                state_q <= DONE;
                valid_q <= 1'b1;
            end else begin
                beat_q <= beat_q + 1'b1;
            end
        end else if (accept) begin
            word_q  <= data_i;
            mode_q  <= INVERSE_EN ? mode_i : 1'b0;
            beat_q  <= '0;
            state_q <= BUSY;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
        end else if (state_q == DONE && out_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end
    end

endmodule
